// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: opcodes, T-state encoding and
// control-word bit positions used by the sequencer and the datapath top.
package cpu_pkg;

    localparam int unsigned OP_W = 4;
    localparam int unsigned ST_W = 7;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_JMP = 4'h3;
    localparam logic [OP_W-1:0] OP_JC  = 4'h4;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // One-hot T-state ring plus the absorbing HALT state
    typedef enum logic [ST_W-1:0] {
        ST_T1   = 7'b000_0001,
        ST_T2   = 7'b000_0010,
        ST_T3   = 7'b000_0100,
        ST_T4   = 7'b000_1000,
        ST_T5   = 7'b001_0000,
        ST_T6   = 7'b010_0000,
        ST_HALT = 7'b100_0000
    } tstate_t;

    localparam int unsigned CW_PC_INC  = 0;
    localparam int unsigned CW_PC_OUT  = 1;
    localparam int unsigned CW_PC_LD   = 2;
    localparam int unsigned CW_MAR_LD  = 3;
    localparam int unsigned CW_RAM_OUT = 4;
    localparam int unsigned CW_IR_LD   = 5;
    localparam int unsigned CW_IR_OUT  = 6;
    localparam int unsigned CW_A_LD    = 7;
    localparam int unsigned CW_A_OUT   = 8;
    localparam int unsigned CW_B_LD    = 9;
    localparam int unsigned CW_ALU_OUT = 10;
    localparam int unsigned CW_ALU_CUT = 11;
    localparam int unsigned CW_OUT_LD  = 12;
    localparam int unsigned CW_HALT    = 13;
    localparam int unsigned CW_W       = 14;

    typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/ctrl_ring.sv
// Six-phase T-state ring counter; T4 diverts into HALT on a halt request,
// and HALT is only left through reset.
module ctrl_ring
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt_req,
    output logic [ST_W-1:0] state
);

    tstate_t state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_T1;
        end else begin
            case (state_q)
                ST_T1:   state_q <= ST_T2;
                ST_T2:   state_q <= ST_T3;
                ST_T3:   state_q <= ST_T4;
                ST_T4:   state_q <= halt_req ? ST_HALT : ST_T5;
                ST_T5:   state_q <= ST_T6;
                ST_T6:   state_q <= ST_T1;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_T1;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ctrl_seq.sv
// Controller-sequencer: decodes opcode and T-state into the control word and
// keeps the carry flag consumed by conditional jump.
module ctrl_seq
    import cpu_pkg::*;
(
    input  logic       ctrl_clk,
    input  logic       ctrl_rst_n,
    input  logic [7:0] ctrl_ir,
    input  logic       ctrl_alu_cy,
    output logic       ctrl_pc_inc,
    output logic       ctrl_pc_out,
    output logic       ctrl_pc_ld,
    output logic       ctrl_mar_ld,
    output logic       ctrl_ram_out,
    output logic       ctrl_ir_ld,
    output logic       ctrl_ir_out,
    output logic       ctrl_a_ld,
    output logic       ctrl_a_out,
    output logic       ctrl_b_ld,
    output logic       ctrl_alu_out,
    output logic       ctrl_alu_cut,
    output logic       ctrl_out_ld,
    output logic       ctrl_halt,
    output logic       ctrl_cy_flag
);

    logic [ST_W-1:0] state;
    logic [OP_W-1:0] opcode;
    logic            halt_req;
    logic            cy_flag;
    logic            is_arith;
    cw_t             cw;
    cw_t             cw_out;
    logic            unused_operand;

    assign opcode         = ctrl_ir[7:4];
    assign unused_operand = ^ctrl_ir[3:0];
    assign is_arith       = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign halt_req       = (state == ST_T4) && (opcode == OP_HLT);

    ctrl_ring u_ring (
        .clk      (ctrl_clk),
        .rst_n    (ctrl_rst_n),
        .halt_req (halt_req),
        .state    (state)
    );

    // Carry/borrow captured only at the end of an ADD/SUB write-back
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            cy_flag <= 1'b0;
        end else if ((state == ST_T6) && is_arith) begin
            cy_flag <= ctrl_alu_cy;
        end
    end

    always_comb begin
        cw = '0;
        case (state)
            ST_T1: begin
                cw[CW_PC_OUT] = 1'b1;
                cw[CW_MAR_LD] = 1'b1;
            end
            ST_T2: cw[CW_PC_INC] = 1'b1;
            ST_T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LD]   = 1'b1;
            end
            ST_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_LD] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_PC_LD]  = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IR_OUT] = cy_flag;
                        cw[CW_PC_LD]  = cy_flag;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_LD] = 1'b1;
                    end
                    OP_HLT:  cw[CW_HALT] = 1'b1;
                    default: cw = '0;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LD]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LD]    = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            ST_T6: begin
                if (is_arith) begin
                    cw[CW_ALU_OUT] = 1'b1;
                    cw[CW_A_LD]    = 1'b1;
                    cw[CW_ALU_CUT] = (opcode == OP_SUB);
                end
            end
            ST_HALT: cw[CW_HALT] = 1'b1;
            default: cw = '0;
        endcase
    end

    // Strobes drop with reset without waiting for a clock edge
    assign cw_out = ctrl_rst_n ? cw : '0;

    assign ctrl_pc_inc  = cw_out[CW_PC_INC];
    assign ctrl_pc_out  = cw_out[CW_PC_OUT];
    assign ctrl_pc_ld   = cw_out[CW_PC_LD];
    assign ctrl_mar_ld  = cw_out[CW_MAR_LD];
    assign ctrl_ram_out = cw_out[CW_RAM_OUT];
    assign ctrl_ir_ld   = cw_out[CW_IR_LD];
    assign ctrl_ir_out  = cw_out[CW_IR_OUT];
    assign ctrl_a_ld    = cw_out[CW_A_LD];
    assign ctrl_a_out   = cw_out[CW_A_OUT];
    assign ctrl_b_ld    = cw_out[CW_B_LD];
    assign ctrl_alu_out = cw_out[CW_ALU_OUT];
    assign ctrl_alu_cut = cw_out[CW_ALU_CUT];
    assign ctrl_out_ld  = cw_out[CW_OUT_LD];
    assign ctrl_halt    = cw_out[CW_HALT];
    assign ctrl_cy_flag = cy_flag;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: per-cycle control words against hand-written tables.
module tb_ctrl_seq;

    localparam logic [13:0] PC_INC  = 14'h2000;
    localparam logic [13:0] PC_OUT  = 14'h1000;
    localparam logic [13:0] PC_LD   = 14'h0800;
    localparam logic [13:0] MAR_LD  = 14'h0400;
    localparam logic [13:0] RAM_OUT = 14'h0200;
    localparam logic [13:0] IR_LD   = 14'h0100;
    localparam logic [13:0] IR_OUT  = 14'h0080;
    localparam logic [13:0] A_LD    = 14'h0040;
    localparam logic [13:0] A_OUT   = 14'h0020;
    localparam logic [13:0] B_LD    = 14'h0010;
    localparam logic [13:0] ALU_OUT = 14'h0008;
    localparam logic [13:0] ALU_CUT = 14'h0004;
    localparam logic [13:0] OUT_LD  = 14'h0002;
    localparam logic [13:0] HALT    = 14'h0001;
    localparam logic [13:0] NONE    = 14'h0000;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] ir;
    logic alu_cy;
    logic pc_inc, pc_out, pc_ld, mar_ld, ram_out, ir_ld, ir_out;
    logic a_ld, a_out, b_ld, alu_out, alu_cut, out_ld, halt, cy_flag;
    logic [13:0] obs;
    logic [13:0] exp [6];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ctrl_seq dut (
        .ctrl_clk     (clk),
        .ctrl_rst_n   (rst_n),
        .ctrl_ir      (ir),
        .ctrl_alu_cy  (alu_cy),
        .ctrl_pc_inc  (pc_inc),
        .ctrl_pc_out  (pc_out),
        .ctrl_pc_ld   (pc_ld),
        .ctrl_mar_ld  (mar_ld),
        .ctrl_ram_out (ram_out),
        .ctrl_ir_ld   (ir_ld),
        .ctrl_ir_out  (ir_out),
        .ctrl_a_ld    (a_ld),
        .ctrl_a_out   (a_out),
        .ctrl_b_ld    (b_ld),
        .ctrl_alu_out (alu_out),
        .ctrl_alu_cut (alu_cut),
        .ctrl_out_ld  (out_ld),
        .ctrl_halt    (halt),
        .ctrl_cy_flag (cy_flag)
    );

    assign obs = {pc_inc, pc_out, pc_ld, mar_ld, ram_out, ir_ld, ir_out,
                  a_ld, a_out, b_ld, alu_out, alu_cut, out_ld, halt};

    // At most one bus driver in any cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            assert ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1)
                passed++;
            else
                $display("FAIL bus_excl: drivers %b want at most one high",
                         {pc_out, ram_out, ir_out, a_out, alu_out});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ir = 8'h50; alu_cy = 1'b0;
        tick();
        total++;
        if (obs !== NONE || cy_flag !== 1'b0)
            $display("FAIL reset_hold: got %h cy %b want 0000 cy 0", obs, cy_flag);
        else passed++;
        tick();
        rst_n = 1'b1;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, NONE, NONE, NONE};
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL reset_nop T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_add();
        ir = 8'h1A;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD};
        for (int i = 0; i < 6; i++) begin
            alu_cy = (i == 5);
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL add T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
        alu_cy = 1'b0;
        total++;
        if (cy_flag !== 1'b1) $display("FAIL add_cy: got %b want 1", cy_flag);
        else passed++;
    endtask

    task automatic test_jc_taken();
        ir = 8'h47;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, IR_OUT | PC_LD, NONE, NONE};
        for (int i = 0; i < 6; i++) begin
            alu_cy = 1'b0;
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL jc_taken T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
        total++;
        if (cy_flag !== 1'b1) $display("FAIL jc_taken_cy: got %b want 1", cy_flag);
        else passed++;
    endtask

    task automatic test_sub();
        ir = 8'h25;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD | ALU_CUT};
        for (int i = 0; i < 6; i++) begin
            alu_cy = (i != 5);
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL sub T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
        alu_cy = 1'b0;
        total++;
        if (cy_flag !== 1'b0) $display("FAIL sub_cy: got %b want 0", cy_flag);
        else passed++;
    endtask

    task automatic test_jc_not_taken();
        ir = 8'h47;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, NONE, NONE, NONE};
        for (int i = 0; i < 6; i++) begin
            alu_cy = 1'b1;
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL jc_skip T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
        alu_cy = 1'b0;
        total++;
        if (cy_flag !== 1'b0) $display("FAIL jc_skip_cy: got %b want 0", cy_flag);
        else passed++;
    endtask

    task automatic test_other_ops();
        logic [7:0]  ops [3];
        logic [13:0] ex4 [3];
        logic [13:0] ex5 [3];
        ops = '{8'h03, 8'h39, 8'hE0};
        ex4 = '{IR_OUT | MAR_LD, IR_OUT | PC_LD, A_OUT | OUT_LD};
        ex5 = '{RAM_OUT | A_LD, NONE, NONE};
        for (int k = 0; k < 3; k++) begin
            ir = ops[k];
            exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, ex4[k], ex5[k], NONE};
            for (int i = 0; i < 6; i++) begin
                alu_cy = 1'b1;
                #1;
                total++;
                if (obs !== exp[i])
                    $display("FAIL op%h T%0d: got %h want %h", ops[k], i + 1, obs, exp[i]);
                else passed++;
                tick();
            end
            total++;
            if (cy_flag !== 1'b0) $display("FAIL op%h_cy: got %b want 0", ops[k], cy_flag);
            else passed++;
        end
        alu_cy = 1'b0;
    endtask

    task automatic test_halt();
        ir = 8'hF0;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, HALT, NONE, NONE};
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL hlt T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
        ir = 8'h1A;
        alu_cy = 1'b1;
        for (int c = 0; c < 22; c++) begin
            #1;
            total++;
            if (obs !== HALT) $display("FAIL halted c%0d: got %h want %h", c, obs, HALT);
            else passed++;
            tick();
        end
        alu_cy = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== NONE) $display("FAIL halt_reset: got %h want 0000", obs);
        else passed++;
        tick();
        ir = 8'h50;
        rst_n = 1'b1;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, NONE, NONE, NONE};
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL post_halt T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_reset_mid_lda();
        ir = 8'h1A;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD};
        for (int i = 0; i < 6; i++) begin
            alu_cy = (i == 5);
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL pre_add T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            tick();
        end
        alu_cy = 1'b0;
        total++;
        if (cy_flag !== 1'b1) $display("FAIL pre_add_cy: got %b want 1", cy_flag);
        else passed++;
        ir = 8'h03;
        exp = '{PC_OUT | MAR_LD, PC_INC, RAM_OUT | IR_LD, IR_OUT | MAR_LD, RAM_OUT | A_LD, NONE};
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (obs !== exp[i]) $display("FAIL mid_lda T%0d: got %h want %h", i + 1, obs, exp[i]);
            else passed++;
            if (i < 4) tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== NONE || cy_flag !== 1'b0)
            $display("FAIL mid_reset: got %h cy %b want 0000 cy 0", obs, cy_flag);
        else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (obs !== (PC_OUT | MAR_LD) || cy_flag !== 1'b0)
            $display("FAIL restart_t1: got %h cy %b want %h cy 0", obs, cy_flag, PC_OUT | MAR_LD);
        else passed++;
        tick();
        #1;
        total++;
        if (obs !== PC_INC) $display("FAIL restart_t2: got %h want %h", obs, PC_INC);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_jc_taken();
        test_sub();
        test_jc_not_taken();
        test_other_ops();
        test_halt();
        test_reset_mid_lda();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Controller-sequencer for the 8-bit bus CPU. It steps a six-phase T-state ring and decodes the instruction register's opcode into the per-phase control word. The control word drives every bus source and load strobe, including the ALU's drive-enable and subtract select. It latches the ALU carry into a flag used by conditional jump. It is the initiator for all bus transfers; the ALU, registers, RAM and PC are responders.

## Interface
Parameters: none (opcodes and state encodings live in the shared package).

- ctrl_clk  in  1  single system clock; all state updates on rising edge
- ctrl_rst_n  in  1  reset, asynchronous, active-low
- ctrl_ir  in  8  instruction register contents; [7:4] opcode, [3:0] operand (operand not used here)
- ctrl_alu_cy  in  1  ALU carry/borrow output (bit 8 of the 9-bit sum/difference)
- ctrl_pc_inc  out  1  PC increment
- ctrl_pc_out  out  1  PC drives bus
- ctrl_pc_ld  out  1  PC loads from bus
- ctrl_mar_ld  out  1  MAR loads from bus
- ctrl_ram_out  out  1  RAM drives bus
- ctrl_ir_ld  out  1  IR loads from bus
- ctrl_ir_out  out  1  IR operand nibble drives bus
- ctrl_a_ld  out  1  register A loads from bus
- ctrl_a_out  out  1  register A drives bus
- ctrl_b_ld  out  1  register B loads from bus
- ctrl_alu_out  out  1  ALU drives bus
- ctrl_alu_cut  out  1  ALU subtract select (1 = A-B, 0 = A+B)
- ctrl_out_ld  out  1  output port loads from bus
- ctrl_halt  out  1  CPU halted; stays high until reset
- ctrl_cy_flag  out  1  latched carry flag

## Operation
- Opcodes: LDA 0x0, ADD 0x1, SUB 0x2, JMP 0x3, JC 0x4, OUT 0xE, HLT 0xF. All others execute as NOP (fetch only).
- States: T1..T6 cycle in order, T6 -> T1. A separate HALT state is absorbing and is left only by reset.
- Fetch, identical for all opcodes:
  - T1: pc_out, mar_ld
  - T2: pc_inc
  - T3: ram_out, ir_ld
- Execute, T4 / T5 / T6:
  - LDA: ir_out+mar_ld / ram_out+a_ld / none
  - ADD: ir_out+mar_ld / ram_out+b_ld / alu_out+a_ld, alu_cut=0
  - SUB: same as ADD, except alu_cut=1 in T6 only
  - JMP: ir_out+pc_ld / none / none
  - JC: ir_out+pc_ld in T4 only if cy_flag=1, otherwise none / none / none
  - OUT: a_out+out_ld / none / none
  - HLT: T4 transitions to HALT on the next edge; ctrl_halt=1 in T4 and in HALT; all other controls 0
- Bus rule: at most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle.
- Carry flag:
  - On the rising edge ending T6 of ADD/SUB, cy_flag <= ctrl_alu_cy.
  - For SUB the captured value is the borrow (1 when A<B unsigned).
  - Holds otherwise, including through JC.
- Control outputs decode combinationally from the state register, ctrl_ir[7:4] and cy_flag only. There is no path from ctrl_alu_cy to any output.

## Timing
- Reset asserted, asynchronously: state=T1, cy_flag=0, ctrl_halt=0, and every control output is forced 0 while ctrl_rst_n is low.
- After release, the first cycle is T1. The instruction fetch completes at the end of T3.
- Every instruction takes exactly 6 cycles; there is no early termination. HLT halts after 4 cycles.
- ctrl_ir must be stable from the T3 edge onward. The opcode decoded in T4-T6 is the one loaded by ir_ld in T3.
- Reset mid-instruction aborts immediately and no partial writes are completed. Any asserted strobe drops asynchronously with reset.

## Structure
- Shared package cpu_pkg:
  - opcode localparams (OP_LDA..OP_HLT)
  - T-state encoding (one-hot, 7 bits including HALT)
  - control-word bit indices, reused by the datapath top
- Sub-module ctrl_ring: T-state ring counter with halt entry. Inputs: clock, reset, halt request. Output: one-hot state.
- ctrl_seq holds the decode logic and the carry flop.

## Test plan
- Reset release, no IR load: cycles 1-3 show exactly {pc_out,mar_ld}, {pc_inc}, {ram_out,ir_ld}; all outputs 0 during reset.
- ctrl_ir=0x1A (ADD), ctrl_alu_cy=1 in T6 -> T4 ir_out+mar_ld, T5 ram_out+b_ld, T6 alu_out+a_ld with alu_cut=0; cy_flag=1 after T6.
- ctrl_ir=0x25 (SUB), ctrl_alu_cy=0 -> T6 alu_cut=1 with alu_out; cy_flag cleared to 0.
- JC 0x47 with cy_flag=1 -> T4 ir_out+pc_ld. Repeat with cy_flag=0 -> T4-T6 all controls 0, cy_flag unchanged.
- ctrl_ir=0xF0 -> ctrl_halt=1 from T4; state held for 20+ cycles with no strobes; reset returns to T1 with halt=0.
- Assert reset in T5 of LDA -> outputs drop to 0 the same cycle; restart in T1 with cy_flag=0. A bus-exclusivity assertion holds throughout every scenario.
